// File: rtl/audio_pkg.sv
// audio_pkg: shared definitions for audio_synth_i2s_tx.
// Holds the waveform select codes, the pan bit indices and the
// divider helper functions used to size the clock-enable counters.
package audio_pkg;
    typedef enum logic [1:0] {
        WAVE_SAW    = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_OFF    = 2'd3
    } wave_e;

    localparam int PAN_L = 0;
    localparam int PAN_R = 1;

    // System clocks per BCK half period: two slots of `width` bits per frame,
    // two half periods per bit.
    function automatic int bck_half(input int ref_clk, input int rate, input int width);
        return ref_clk / (rate * width * 4);
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return n <= 1 ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/synth_voice.sv
// synth_voice: one phase-accumulator oscillator with waveform generator.
// Ports:
//   iCLK_18_4  system clock
//   iRST       synchronous active-high reset
//   iTICK      frame tick; all inputs are sampled and the phase advanced here
//   iKEY_ON    gate; when low at a tick the phase is cleared and the output is 0
//   iPHASE_INC phase increment per frame (natural wrap)
//   iWAVE_SEL  waveform code (saw, square, triangle, silent)
//   oWAVE      signed sample derived from the updated phase
module synth_voice
    import audio_pkg::*;
#(
    parameter int PHASE_W    = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                         iCLK_18_4,
    input  logic                         iRST,
    input  logic                         iTICK,
    input  logic                         iKEY_ON,
    input  logic [PHASE_W-1:0]           iPHASE_INC,
    input  logic [1:0]                   iWAVE_SEL,
    output logic signed [DATA_WIDTH-1:0] oWAVE
);
    localparam logic [DATA_WIDTH-1:0] SQ_POS = {2'b01, {(DATA_WIDTH-2){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] SQ_NEG = {2'b11, {(DATA_WIDTH-2){1'b0}}};

    logic [PHASE_W-1:0]    phase;
    wave_e                 sel;
    logic                  key;
    logic [DATA_WIDTH-1:0] saw;
    logic [DATA_WIDTH-1:0] tri_raw;
    logic [DATA_WIDTH-1:0] tri_fold;

    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            phase <= '0;
            sel   <= WAVE_SAW;
            key   <= 1'b0;
        end else if (iTICK) begin
            phase <= iKEY_ON ? phase + iPHASE_INC : '0;
            sel   <= wave_e'(iWAVE_SEL);
            key   <= iKEY_ON;
        end
    end

    // The triangle window sits one bit below the phase MSB; zero-filling
    // below the phase keeps it defined when PHASE_W equals DATA_WIDTH.
    always_comb begin
        saw      = DATA_WIDTH'(phase >> (PHASE_W - DATA_WIDTH));
        tri_raw  = DATA_WIDTH'({phase[PHASE_W-2:0], {DATA_WIDTH{1'b0}}} >> (PHASE_W - 1));
        tri_fold = phase[PHASE_W-1] ? ~tri_raw : tri_raw;
        oWAVE    = !key                ? '0 :
                   sel == WAVE_SAW     ? {~saw[DATA_WIDTH-1], saw[DATA_WIDTH-2:0]} :
                   sel == WAVE_SQUARE  ? (phase[PHASE_W-1] ? SQ_NEG : SQ_POS) :
                   sel == WAVE_TRI     ? {~tri_fold[DATA_WIDTH-1], tri_fold[DATA_WIDTH-2:0]} :
                                         '0;
    end
endmodule

// File: rtl/audio_synth_i2s_tx.sv
// audio_synth_i2s_tx: multi-voice synthesiser driving a stereo codec DAC.
// BCK/LRCK are generated from iCLK_18_4 with clock enables only; NUM_VOICES
// oscillators are panned, shifted, summed with saturation and serialised MSB first.
// Ports:
//   iCLK_18_4   system clock
//   iRST        synchronous active-high reset
//   iKEY_ON     per-voice gate
//   iPHASE_INC  per-voice increment, voice i at [i*PHASE_W +: PHASE_W]
//   iWAVE_SEL   per-voice waveform code, 2 bits each
//   iPAN        per-voice routing, bit0 left enable, bit1 right enable
//   oAUD_BCK    bit clock
//   oAUD_LRCK   word clock, 0 = left slot, 1 = right slot
//   oAUD_DATA   serial data, MSB first
//   oFRAME_TICK one-cycle pulse at each frame start
// Build option: define I2S_DELAY_EN for Philips I2S (data one BCK behind LRCK);
// left-justified otherwise.
module audio_synth_i2s_tx
    import audio_pkg::*;
#(
    parameter int REF_CLK     = 18432000,
    parameter int SAMPLE_RATE = 48000,
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_VOICES  = 4,
    parameter int PHASE_W     = 16,
    parameter int VOICE_SHIFT = 2
) (
    input  logic                          iCLK_18_4,
    input  logic                          iRST,
    input  logic [NUM_VOICES-1:0]         iKEY_ON,
    input  logic [NUM_VOICES*PHASE_W-1:0] iPHASE_INC,
    input  logic [NUM_VOICES*2-1:0]       iWAVE_SEL,
    input  logic [NUM_VOICES*2-1:0]       iPAN,
    output logic                          oAUD_BCK,
    output logic                          oAUD_LRCK,
    output logic                          oAUD_DATA,
    output logic                          oFRAME_TICK
);
    localparam int HALF  = bck_half(REF_CLK, SAMPLE_RATE, DATA_WIDTH);
    localparam int DIV_W = cnt_w(HALF);
    localparam int BIT_W = cnt_w(DATA_WIDTH);
    localparam int SUM_W = DATA_WIDTH + $clog2(NUM_VOICES) + 1;
    localparam logic signed [SUM_W-1:0] S_MAX = {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] S_MIN = {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [DIV_W-1:0]             div_cnt;
    logic [BIT_W-1:0]             bit_cnt;
    logic [NUM_VOICES*2-1:0]      pan_q;
    logic signed [DATA_WIDTH-1:0] voice [NUM_VOICES];
    logic signed [DATA_WIDTH-1:0] vs;
    logic signed [SUM_W-1:0]      sum_l, sum_r;
    logic [DATA_WIDTH-1:0]        mix_l, mix_r, mix_l_d, mix_r_d;
    logic [DATA_WIDTH-1:0]        sr_l, sr_r, sr_l_d, sr_r_d, l_src, r_src;
    logic                         div_hit, bck_fall, slot_end, frame_start, lrck_d, lj_bit;
`ifdef I2S_DELAY_EN
    logic                         data_q;
`endif

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        synth_voice #(
            .PHASE_W    (PHASE_W),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_voice (
            .iCLK_18_4  (iCLK_18_4),
            .iRST       (iRST),
            .iTICK      (oFRAME_TICK),
            .iKEY_ON    (iKEY_ON[v]),
            .iPHASE_INC (iPHASE_INC[v*PHASE_W +: PHASE_W]),
            .iWAVE_SEL  (iWAVE_SEL[2*v +: 2]),
            .oWAVE      (voice[v])
        );
    end

    always_comb begin
        vs    = '0;
        sum_l = '0;
        sum_r = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            vs    = voice[i] >>> VOICE_SHIFT;
            sum_l = sum_l + (pan_q[2*i+PAN_L] ? {{(SUM_W-DATA_WIDTH){vs[DATA_WIDTH-1]}}, vs} : '0);
            sum_r = sum_r + (pan_q[2*i+PAN_R] ? {{(SUM_W-DATA_WIDTH){vs[DATA_WIDTH-1]}}, vs} : '0);
        end
        mix_l_d = sum_l > S_MAX ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
                  sum_l < S_MIN ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : sum_l[DATA_WIDTH-1:0];
        mix_r_d = sum_r > S_MAX ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
                  sum_r < S_MIN ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : sum_r[DATA_WIDTH-1:0];
    end

    // Every slot/serial event happens on the edge where BCK falls. A frame
    // starts on the slot boundary leaving the right slot; both words are
    // captured there from the mix produced after the previous tick.
    always_comb begin
        div_hit     = div_cnt == DIV_W'(HALF - 1);
        bck_fall    = div_hit && oAUD_BCK;
        slot_end    = bit_cnt == BIT_W'(DATA_WIDTH - 1);
        frame_start = bck_fall && slot_end && oAUD_LRCK;
        lrck_d      = slot_end ? ~oAUD_LRCK : oAUD_LRCK;
        l_src       = frame_start ? mix_l : sr_l;
        r_src       = frame_start ? mix_r : sr_r;
        lj_bit      = lrck_d ? r_src[DATA_WIDTH-1] : l_src[DATA_WIDTH-1];
        sr_l_d      = lrck_d ? l_src : l_src << 1;
        sr_r_d      = lrck_d ? r_src << 1 : r_src;
    end

    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            oAUD_BCK    <= 1'b0;
            oAUD_LRCK   <= 1'b0;
            oAUD_DATA   <= 1'b0;
            oFRAME_TICK <= 1'b0;
            pan_q       <= '0;
            mix_l       <= '0;
            mix_r       <= '0;
            sr_l        <= '0;
            sr_r        <= '0;
`ifdef I2S_DELAY_EN
            data_q      <= 1'b0;
`endif
        end else begin
            div_cnt     <= div_hit ? '0 : div_cnt + 1'b1;
            oAUD_BCK    <= div_hit ? ~oAUD_BCK : oAUD_BCK;
            oFRAME_TICK <= frame_start;
            mix_l       <= mix_l_d;
            mix_r       <= mix_r_d;
            if (oFRAME_TICK)
                pan_q <= iPAN;
            if (bck_fall) begin
                bit_cnt   <= slot_end ? '0 : bit_cnt + 1'b1;
                oAUD_LRCK <= lrck_d;
                sr_l      <= sr_l_d;
                sr_r      <= sr_r_d;
`ifdef I2S_DELAY_EN
                data_q    <= lj_bit;
                oAUD_DATA <= data_q;
`else
                oAUD_DATA <= lj_bit;
`endif
            end
        end
    end
endmodule

// File: tb/tb_audio_synth_i2s_tx.sv
// tb_audio_synth_i2s_tx: self-checking bench for audio_synth_i2s_tx (VOICE_SHIFT 2 and 0 instances).
module tb_audio_synth_i2s_tx;
    localparam int NV = 4;
    localparam int PW = 16;
`ifdef I2S_DELAY_EN
    localparam int DLY = 1;
`else
    localparam int DLY = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NV-1:0]      key;
    logic [PW-1:0]      inc [NV];
    logic [1:0]         sel [NV];
    logic [1:0]         pan [NV];
    logic [NV*PW-1:0]   inc_v;
    logic [2*NV-1:0]    sel_v, pan_v;
    logic [1:0]         bck, lrck, data, tick;

    always_comb begin
        inc_v = '0;
        sel_v = '0;
        pan_v = '0;
        for (int i = 0; i < NV; i++) begin
            inc_v[i*PW +: PW] = inc[i];
            sel_v[2*i +: 2]   = sel[i];
            pan_v[2*i +: 2]   = pan[i];
        end
    end

    audio_synth_i2s_tx dut (
        .iCLK_18_4(clk), .iRST(rst), .iKEY_ON(key), .iPHASE_INC(inc_v),
        .iWAVE_SEL(sel_v), .iPAN(pan_v), .oAUD_BCK(bck[0]), .oAUD_LRCK(lrck[0]),
        .oAUD_DATA(data[0]), .oFRAME_TICK(tick[0])
    );

    audio_synth_i2s_tx #(.VOICE_SHIFT(0)) dut_s0 (
        .iCLK_18_4(clk), .iRST(rst), .iKEY_ON(key), .iPHASE_INC(inc_v),
        .iWAVE_SEL(sel_v), .iPAN(pan_v), .oAUD_BCK(bck[1]), .oAUD_LRCK(lrck[1]),
        .oAUD_DATA(data[1]), .oFRAME_TICK(tick[1])
    );

    int checks = 0;
    int errors = 0;
    int n = 0;
    logic chk_en = 1'b0;

    // Model state: phases, and the 16-bit words each frame carries, per instance.
    int ph [NV];
    int wl [2][128];
    int wr [2][128];
    int shifts [2] = '{2, 0};

    always @(posedge clk) n <= rst ? 0 : n + 1;

    task automatic chk_bit(input string name, input int s, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d n=%0d got %b expected %b", name, s, n, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int wave(input int p, input int s);
        int t;
        case (s)
            0: return p - 32768;
            1: return p < 32768 ? 16384 : -16384;
            2: begin
                t = (p * 2) % 65536;
                if (p >= 32768) t = 65535 - t;
                return t - 32768;
            end
            default: return 0;
        endcase
    endfunction

    function automatic int sat16(input int v);
        return v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
    endfunction

    function automatic logic exp_data(input int s, input int f);
        int w, fr;
        if (f < 0) return 1'b0;
        fr = f / 32;
        if (fr > 127) return 1'b0;
        w = ((f / 16) % 2 == 1) ? wr[s][fr] : wl[s][fr];
        return ((w >> (15 - f % 16)) & 1) == 1;
    endfunction

    always @(negedge clk) begin : cmp
        int o, l, r, k;
        if (chk_en) begin
            if (n == 0) begin
                for (int i = 0; i < NV; i++) ph[i] = 0;
                for (int s = 0; s < 2; s++)
                    for (int j = 0; j < 128; j++) begin
                        wl[s][j] = 0;
                        wr[s][j] = 0;
                    end
            end else if (n % 384 == 0) begin
                k = n / 384;
                for (int i = 0; i < NV; i++)
                    ph[i] = key[i] ? (ph[i] + int'(inc[i])) % 65536 : 0;
                for (int s = 0; s < 2; s++) begin
                    l = 0;
                    r = 0;
                    for (int i = 0; i < NV; i++) begin
                        o = key[i] ? wave(ph[i], int'(sel[i])) : 0;
                        if (pan[i][0]) l += o >>> shifts[s];
                        if (pan[i][1]) r += o >>> shifts[s];
                    end
                    if (k + 1 < 128) begin
                        wl[s][k+1] = sat16(l) & 32'hFFFF;
                        wr[s][k+1] = sat16(r) & 32'hFFFF;
                    end
                end
            end
            for (int s = 0; s < 2; s++) begin
                chk_bit("bck", s, bck[s], ((n / 6) % 2) == 1);
                chk_bit("lrck", s, lrck[s], ((n / 192) % 2) == 1);
                chk_bit("tick", s, tick[s], n > 0 && n % 384 == 0);
                chk_bit("data", s, data[s], exp_data(s, n / 12 - DLY));
            end
        end
    end

    task automatic go(input int target);
        int budget;
        budget = 50000;
        while (n < target && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        if (n < target) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for n=%0d got %0d", target, n);
        end
    endtask

    task automatic set_voice(input int i, input logic k, input logic [15:0] c, input logic [1:0] w, input logic [1:0] p);
        key[i] = k;
        inc[i] = c;
        sel[i] = w;
        pan[i] = p;
    endtask

    initial begin
        key = '0;
        for (int i = 0; i < NV; i++) set_voice(i, 1'b0, 16'h0, 2'd0, 2'd0);
        repeat (3) @(posedge clk);
        #2;
        for (int s = 0; s < 2; s++) begin
            chk_bit("reset_bck", s, bck[s], 1'b0);
            chk_bit("reset_lrck", s, lrck[s], 1'b0);
            chk_bit("reset_data", s, data[s], 1'b0);
            chk_bit("reset_tick", s, tick[s], 1'b0);
        end
        chk_en = 1'b1;
        rst = 1'b0;

        go(384 * 3 + 100);
        set_voice(0, 1'b1, 16'h0400, 2'd0, 2'd3);
        go(384 * 7 + 100);
        chk_int("saw_first_l", wl[0][5], 16'hE100);
        chk_int("saw_first_r", wr[0][5], 16'hE100);
        chk_int("saw_next_l", wl[0][6], 16'hE200);

        set_voice(0, 1'b1, 16'h8000, 2'd1, 2'd3);
        go(384 * 11 + 100);
        chk_int("square_neg", wl[0][9], 16'hF000);
        chk_int("square_pos", wl[0][10], 16'h1000);

        for (int i = 0; i < NV; i++) set_voice(i, 1'b1, 16'h0, 2'd1, 2'd1);
        go(384 * 13 + 100);
        chk_int("sat_left", wl[1][13], 16'h7FFF);
        chk_int("sat_right", wr[1][13], 16'h0000);
        chk_int("sum4_left", wl[0][13], 16'h4000);

        key[0] = 1'b0;
        go(384 * 13 + 120);
        key[0] = 1'b1;
        go(384 * 15 + 100);
        key = '0;
        go(384 * 16 + 100);
        set_voice(0, 1'b1, 16'h0400, 2'd0, 2'd3);
        go(384 * 18 + 100);
        chk_int("missed_pulse", wl[0][16], 16'h4000);
        chk_int("key_off", wl[0][17], 16'h0000);
        chk_int("rekey", wl[0][18], 16'hE100);

        go(384 * 19 + 150);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            chk_bit("midrst_bck", s, bck[s], 1'b0);
            chk_bit("midrst_lrck", s, lrck[s], 1'b0);
            chk_bit("midrst_data", s, data[s], 1'b0);
            chk_bit("midrst_tick", s, tick[s], 1'b0);
        end
        go(384);
        chk_bit("post_rst_tick", 0, tick[0], 1'b1);
        chk_bit("post_rst_lrck", 0, lrck[0], 1'b0);
        go(768);
        chk_int("post_rst_word", wl[0][2], 16'hE100);
        chk_bit("msb_pos0", 0, data[0], DLY == 1 ? 1'b0 : 1'b1);
        go(780);
        chk_bit("msb_pos1", 0, data[0], 1'b1);
        go(384 * 3 + 10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
